mips_state_dumper: RTL and testbench

//  Post-run reader for the MIPS datapath: the counterpart of the program loader that writes instruction memory.
//  On start, takes over the register-file read port and the data-memory read port through the top-level muxes.

---
 rtl/mips_state_dumper_pkg.sv | 22 ++
 rtl/mips_state_dumper_if.sv | 32 +++
 rtl/mips_state_dumper.sv | 105 ++++++++++
 tb/tb_mips_state_dumper.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_state_dumper_pkg.sv
// Shared types for the MIPS post-run state dumper: FSM state encodings, record kinds
// and the word-index to byte-address helper.
package mips_state_dumper_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REG_RD   = 3'd1,
        S_MEM_REQ  = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_EMIT     = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    // Data memory is byte addressed; the scan walks whole words.
    function automatic logic [31:0] word_addr(input logic [15:0] idx);
        return {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/mips_state_dumper_if.sv
// Datapath read ports, control and record stream of the state dumper.
// master = dumper side, slave = datapath muxes plus record consumer.
interface mips_state_dumper_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              done;
    logic              dumpActive;
    logic [4:0]        regAddr;
    logic [DATA_W-1:0] regData;
    logic [31:0]       memAddr;
    logic              memRead;
    logic              loadFullWord;
    logic [DATA_W-1:0] memData;
    logic              outValid;
    logic              outReady;
    logic              outIsMem;
    logic [15:0]       outIndex;
    logic [DATA_W-1:0] outData;

    modport master (
        input  start, regData, memData, outReady,
        output done, dumpActive, regAddr, memAddr, memRead, loadFullWord,
               outValid, outIsMem, outIndex, outData
    );

    modport slave (
        output start, regData, memData, outReady,
        input  done, dumpActive, regAddr, memAddr, memRead, loadFullWord,
               outValid, outIsMem, outIndex, outData
    );
endinterface

// File: rtl/mips_state_dumper.sv
// Scans registers then data-memory words into tagged records: 2 cycles/register, 3/memory word.
// Records hold stable in EMIT while outReady is low; no memory read is issued during a stall.
module mips_state_dumper
    import mips_state_dumper_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int MEM_WORDS = 64,
    parameter int DATA_W    = 32
) (
    input logic                 clk,
    input logic                 reset,
    mips_state_dumper_if.master dif
);

    localparam logic [15:0] LAST_REG = 16'(NUM_REGS - 1);
    localparam logic [15:0] LAST_MEM = 16'(MEM_WORDS - 1);
    localparam bit          HAS_MEM  = (MEM_WORDS != 0);

    state_e            state_q, state_d;
    logic [15:0]       idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       index_q, index_d;
    logic              is_mem_q, is_mem_d;
    logic              active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            data_q   <= '0;
            index_q  <= '0;
            is_mem_q <= KIND_REG;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            index_q  <= index_d;
            is_mem_q <= is_mem_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        index_d  = index_q;
        is_mem_d = is_mem_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (dif.start) begin
                    state_d = S_REG_RD;
                    idx_d   = '0;
                end
            end
            S_REG_RD: begin
                data_d   = dif.regData;
                index_d  = idx_q;
                is_mem_d = KIND_REG;
                state_d  = S_EMIT;
            end
            S_MEM_REQ: begin
                state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                data_d   = dif.memData;
                index_d  = idx_q;
                is_mem_d = KIND_MEM;
                state_d  = S_EMIT;
            end
            S_EMIT: begin
                if (dif.outReady) begin
                    if (is_mem_q == KIND_REG) begin
                        if (idx_q < LAST_REG) begin
                            idx_d   = idx_q + 16'd1;
                            state_d = S_REG_RD;
                        end else begin
                            idx_d   = '0;
                            state_d = HAS_MEM ? S_MEM_REQ : S_DONE;
                        end
                    end else if (idx_q < LAST_MEM) begin
                        idx_d   = idx_q + 16'd1;
                        state_d = S_MEM_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All outputs decode registered state, so an async reset clears them immediately.
    assign active           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign dif.dumpActive   = active;
    assign dif.loadFullWord = active;
    assign dif.regAddr      = idx_q[4:0];
    assign dif.memAddr      = word_addr(idx_q);
    assign dif.memRead      = (state_q == S_MEM_REQ);
    assign dif.outValid     = (state_q == S_EMIT);
    assign dif.outIsMem     = is_mem_q;
    assign dif.outIndex     = index_q;
    assign dif.outData      = data_q;
    assign dif.done         = (state_q == S_DONE);

endmodule

// File: tb/tb_mips_state_dumper.sv
// Bench for mips_state_dumper: a 4-word-memory instance and a register-only instance,
// with register-file and data-memory models and a queue of expected records.
module tb_mips_state_dumper;

    typedef struct packed {
        logic        vld;
        logic        act;
        logic        lfw;
        logic        mrd;
        logic        dn;
        logic        ismem;
        logic [15:0] idx;
        logic [31:0] dat;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start4, start0, rdy4, rdy0;
    logic [31:0] regfile [32];
    logic [31:0] memarr  [4];
    logic [31:0] mrd4_q;
    logic [48:0] q [$];
    bit          mem_ever;
    int          total, bad;

    always #5 clk = ~clk;

    mips_state_dumper_if #(.DATA_W(32)) if4 ();
    mips_state_dumper_if #(.DATA_W(32)) if0 ();

    mips_state_dumper #(.NUM_REGS(32), .MEM_WORDS(4), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .dif(if4)
    );
    mips_state_dumper #(.NUM_REGS(32), .MEM_WORDS(0), .DATA_W(32)) dut0 (
        .clk(clk), .reset(reset), .dif(if0)
    );

    assign if4.start    = start4;
    assign if4.outReady = rdy4;
    assign if4.regData  = regfile[if4.regAddr];
    assign if4.memData  = mrd4_q;
    assign if0.start    = start0;
    assign if0.outReady = rdy0;
    assign if0.regData  = regfile[if0.regAddr];
    assign if0.memData  = 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (if4.memRead) mrd4_q <= memarr[if4.memAddr[3:2]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic snap_t snap(input int sel);
        snap_t s;
        if (sel == 0) begin
            s = {if0.outValid, if0.dumpActive, if0.loadFullWord, if0.memRead, if0.done,
                 if0.outIsMem, if0.outIndex, if0.outData};
        end else begin
            s = {if4.outValid, if4.dumpActive, if4.loadFullWord, if4.memRead, if4.done,
                 if4.outIsMem, if4.outIndex, if4.outData};
        end
        return s;
    endfunction

    task automatic drive(input int sel, input logic st, input logic rd);
        if (sel == 0) begin
            start0 = st;
            rdy0   = rd;
        end else begin
            start4 = st;
            rdy4   = rd;
        end
    endtask

    task automatic push_all(input int sel);
        for (int r = 0; r < 32; r++) q.push_back({1'b0, 16'(r), regfile[r]});
        if (sel != 0) begin
            for (int m = 0; m < 4; m++) q.push_back({1'b1, 16'(m), memarr[m]});
        end
    endtask

    task automatic pulse(input int sel);
        drive(sel, 1'b1, 1'b1);
        tick();
        drive(sel, 1'b0, 1'b1);
    endtask

    // Called on the cycle after start is sampled; cycle 0 is the first REG_RD.
    task automatic drain(input int sel, input int exp_done, input int exp_recs,
                         input int stall_idx, input int start_idx);
        snap_t       s, held;
        int          cyc = 0, got = 0, stall = 0, done_cyc = -1;
        bit          stable_ok = 1, rd_in_emit = 0, st_sent = 0, act_ok = 0;
        logic        r, st;
        logic [48:0] e;
        held = '0;
        while (cyc < 400) begin
            s = snap(sel);
            if (s.dn) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == 0) act_ok = s.act && s.lfw;
            if (s.vld && s.mrd) rd_in_emit = 1;
            if (s.mrd && sel == 0) mem_ever = 1;
            r  = 1'b1;
            st = 1'b0;
            if (s.vld && !s.ismem && s.idx == 16'(stall_idx) && stall < 10) begin
                r = 1'b0;
                if (stall == 0) held = s;
                else if (s !== held) stable_ok = 0;
                stall++;
            end
            if (s.vld && !s.ismem && s.idx == 16'(start_idx) && !st_sent) begin
                st      = 1'b1;
                st_sent = 1;
            end
            if (s.vld && r) begin
                got++;
                e = (q.size() > 0) ? q.pop_front() : 'x;
                chk("record", {15'd0, s.ismem, s.idx, s.dat}, {15'd0, e});
            end
            drive(sel, st, r);
            tick();
            cyc++;
        end
        drive(sel, 1'b0, 1'b0);
        chk("done_cycle", 64'(done_cyc), 64'(exp_done));
        chk("record_count", 64'(got), 64'(exp_recs));
        chk("stall_stable", 64'(stable_ok), 64'd1);
        chk("active_at_start", 64'(act_ok), 64'd1);
        chk("no_read_in_emit", 64'(rd_in_emit), 64'd0);
        chk("queue_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        snap_t s;
        bit    found;
        total    = 0;
        bad      = 0;
        mem_ever = 0;
        reset    = 1'b1;
        start4   = 1'b0;
        start0   = 1'b0;
        rdy4     = 1'b0;
        rdy0     = 1'b0;
        for (int i = 0; i < 32; i++) regfile[i] = 32'hA5A5_0000 ^ 32'(i * 13);
        regfile[0]  = 32'h0000_0000;
        regfile[5]  = 32'h0000_0005;
        regfile[31] = 32'hFFFF_FFFD;
        memarr[0] = 32'd11;
        memarr[1] = 32'd22;
        memarr[2] = 32'd33;
        memarr[3] = 32'd44;

        tick();
        tick();
        s = snap(4);
        chk("reset_valid", 64'(s.vld), 64'd0);
        chk("reset_active", 64'(s.act), 64'd0);
        chk("reset_lfw", 64'(s.lfw), 64'd0);
        chk("reset_memread", 64'(s.mrd), 64'd0);
        chk("reset_done", 64'(s.dn), 64'd0);
        chk("reset_data", 64'(s.dat), 64'd0);
        chk("reset_index", 64'(s.idx), 64'd0);
        reset = 1'b0;
        tick();

        // Full dump with outReady held high.
        push_all(4);
        pulse(4);
        drain(4, 76, 36, -1, -1);
        tick();
        tick();
        tick();
        s = snap(4);
        chk("done_held", 64'(s.dn), 64'd1);
        chk("done_inactive", 64'(s.act), 64'd0);
        chk("done_no_valid", 64'(s.vld), 64'd0);

        // Re-dump from DONE: stall idx7 for 10 cycles, start pulse during EMIT of idx3.
        push_all(4);
        pulse(4);
        drain(4, 86, 36, 7, 3);

        // Reset in MEM_WAIT of memory word 2.
        pulse(4);
        found = 0;
        for (int n = 0; n < 200; n++) begin
            if (if4.memRead && if4.memAddr == 32'd8) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("found_mem_req2", 64'(found), 64'd1);
        tick();
        reset = 1'b1;
        #1;
        s = snap(4);
        chk("midreset_active", 64'(s.act), 64'd0);
        chk("midreset_valid", 64'(s.vld), 64'd0);
        chk("midreset_memread", 64'(s.mrd), 64'd0);
        chk("midreset_data", 64'(s.dat), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        push_all(4);
        pulse(4);
        drain(4, 76, 36, -1, -1);

        // Register-only instance goes straight to DONE after $31.
        push_all(0);
        pulse(0);
        drain(0, 64, 32, -1, -1);
        chk("nomem_memread_never", 64'(mem_ever), 64'd0);
        s = snap(0);
        chk("nomem_done", 64'(s.dn), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
